// File: rtl/acc_rd_addr_gen_if.sv
// Control-side bundle of the accumulator read-address sequencer:
// start/parameters/stall in, busy/done/per-column read enables and addresses out.
interface acc_rd_addr_gen_if #(
  parameter int unsigned MUL_SIZE = 32,
  parameter int unsigned ADDR_W   = 7
);
  logic                         start_i;
  logic                         mode_i;
  logic [ADDR_W-1:0]            base_addr_i;
  logic [7:0]                   num_rows_i;
  logic                         stall_i;
  logic                         busy_o;
  logic                         done_o;
  logic [MUL_SIZE-1:0]          rd_en_o;
  logic [MUL_SIZE*ADDR_W-1:0]   rd_addr_o;

  modport master (
    output start_i, mode_i, base_addr_i, num_rows_i, stall_i,
    input  busy_o, done_o, rd_en_o, rd_addr_o
  );

  modport slave (
    input  start_i, mode_i, base_addr_i, num_rows_i, stall_i,
    output busy_o, done_o, rd_en_o, rd_addr_o
  );
endinterface

// File: rtl/acc_rd_addr_gen.sv
// Walks a block of accumulator rows and drives per-column read enables/addresses,
// either all columns on the same row (NORMAL) or column c lagging c steps (DIAG).
module acc_rd_addr_gen #(
  parameter int unsigned MUL_SIZE = 32,
  parameter int unsigned ADDR_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  acc_rd_addr_gen_if.slave bus
);

  localparam int unsigned MAX_ROWS = 1 << ADDR_W;
  localparam int unsigned STEP_W   = $clog2(MAX_ROWS + MUL_SIZE) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     state;
  logic                       mode;
  logic [ADDR_W-1:0]          base;
  logic [STEP_W-1:0]          rows;
  logic [STEP_W-1:0]          last;
  logic [STEP_W-1:0]          t;
  logic                       busy;
  logic                       done_pulse;
  logic [MUL_SIZE-1:0]        rd_en;
  logic [MUL_SIZE*ADDR_W-1:0] rd_addr;

  logic [STEP_W-1:0]          req_rows;
  logic [STEP_W-1:0]          req_last;
  logic                       sel_mode;
  logic [ADDR_W-1:0]          sel_base;
  logic [STEP_W-1:0]          sel_rows;
  logic [STEP_W-1:0]          sel_t;
  logic [MUL_SIZE-1:0]        step_en;
  logic [MUL_SIZE*ADDR_W-1:0] step_addr;

  // Clamp the requested row count and derive the index of the final step.
  always_comb begin
    req_rows = (STEP_W'(bus.num_rows_i) > STEP_W'(MAX_ROWS)) ? STEP_W'(MAX_ROWS)
                                                             : STEP_W'(bus.num_rows_i);
    req_last = bus.mode_i ? req_rows + STEP_W'(MUL_SIZE - 2) : req_rows - STEP_W'(1);
  end

  // Outputs are registered, so evaluate the step about to be presented:
  // step 0 of the incoming command in IDLE, otherwise step t+1 of the latched one.
  always_comb begin
    if (state == IDLE) begin
      sel_mode = bus.mode_i;
      sel_base = bus.base_addr_i;
      sel_rows = req_rows;
      sel_t    = '0;
    end else begin
      sel_mode = mode;
      sel_base = base;
      sel_rows = rows;
      sel_t    = t + STEP_W'(1);
    end
  end

  for (genvar c = 0; c < MUL_SIZE; c++) begin : g_col
    localparam logic [STEP_W-1:0] COL = STEP_W'(c);
    logic hit;
    assign hit          = (sel_t >= COL) && (sel_t < COL + sel_rows);
    assign step_en[c]   = ~sel_mode | hit;
    assign step_addr[c*ADDR_W +: ADDR_W] =
        !sel_mode ? sel_base + ADDR_W'(sel_t)
      : hit       ? sel_base + ADDR_W'(sel_t - COL)
      :             '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode       <= 1'b0;
      base       <= '0;
      rows       <= '0;
      last       <= '0;
      t          <= '0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
      rd_en      <= '0;
      rd_addr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_pulse <= 1'b0;
          if (bus.start_i) begin
            mode <= bus.mode_i;
            base <= bus.base_addr_i;
            rows <= req_rows;
            last <= req_last;
            t    <= '0;
            if (req_rows == '0) begin
              state      <= DONE;
              done_pulse <= 1'b1;
            end else begin
              state   <= RUN;
              busy    <= 1'b1;
              rd_en   <= step_en;
              rd_addr <= step_addr;
            end
          end
        end
        RUN: begin
          // A stalled cycle holds every register.
          if (!bus.stall_i) begin
            if (t == last) begin
              state      <= DONE;
              busy       <= 1'b0;
              done_pulse <= 1'b1;
              t          <= '0;
              rd_en      <= '0;
              rd_addr    <= '0;
            end else begin
              t       <= t + STEP_W'(1);
              rd_en   <= step_en;
              rd_addr <= step_addr;
            end
          end
        end
        DONE: begin
          done_pulse <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o    = busy;
  assign bus.done_o    = done_pulse;
  assign bus.rd_en_o   = rd_en;
  assign bus.rd_addr_o = rd_addr;

endmodule

// File: tb/tb_acc_rd_addr_gen.sv
// Scoreboard bench for acc_rd_addr_gen: the driver queues the expected step sequence
// of each command, an independent monitor compares every presented step and done pulse.
module tb_acc_rd_addr_gen;

  localparam int unsigned MUL  = 32;
  localparam int unsigned AW   = 7;
  localparam int unsigned NROW = 1 << AW;

  typedef struct packed {
    logic                is_done;
    logic [MUL-1:0]      en;
    logic [MUL*AW-1:0]   addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  acc_rd_addr_gen_if #(.MUL_SIZE(MUL), .ADDR_W(AW)) bus ();

  acc_rd_addr_gen #(.MUL_SIZE(MUL), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [MUL*AW-1:0] act, input logic [MUL*AW-1:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Reference: each column c reads rows base..base+R-1 one per step, starting at
  // step c in DIAG and step 0 in NORMAL; steps with no reads for a column leave it idle.
  task automatic push_exp(input bit m, input logic [AW-1:0] b, input logic [7:0] n);
    exp_t tab [NROW + MUL];
    int   r;
    int   steps;
    exp_t dm;
    r     = (int'(n) > int'(NROW)) ? int'(NROW) : int'(n);
    steps = (r == 0) ? 0 : (m ? r + int'(MUL) - 1 : r);
    for (int s = 0; s < steps; s++) tab[s] = '0;
    for (int i = 0; i < r; i++) begin
      for (int c = 0; c < int'(MUL); c++) begin
        int st;
        st = m ? i + c : i;
        tab[st].en[c] = 1'b1;
        tab[st].addr[c*AW +: AW] = AW'((int'(b) + i) % int'(NROW));
      end
    end
    for (int s = 0; s < steps; s++) sb.push_back(tab[s]);
    dm = '0;
    dm.is_done = 1'b1;
    sb.push_back(dm);
  endtask

  // Monitor: pops a step when it was consumed at the edge, then checks the new outputs.
  initial begin : monitor
    bit   busy_q;
    bit   stall_e;
    bit   rst_e;
    exp_t e;
    busy_q = 1'b0;
    forever begin
      @(posedge clk);
      stall_e = bus.stall_i;
      rst_e   = rst;
      if (!rst_e && busy_q && !stall_e && sb.size() > 0 && !sb[0].is_done)
        void'(sb.pop_front());
      #1;
      busy_q = bus.busy_o;
      if (bus.done_o) begin
        if (sb.size() == 0) begin
          chk(1'b0, "done_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk(e.is_done, "done_early", 1, {223'b0, e.is_done});
          chk(bus.rd_en_o == '0 && !bus.busy_o, "done_outputs",
              {191'b0, bus.busy_o, bus.rd_en_o}, 0);
        end
      end else if (bus.busy_o) begin
        if (sb.size() == 0 || sb[0].is_done) begin
          chk(1'b0, "busy_extra", 1, 0);
        end else begin
          chk(bus.rd_en_o == sb[0].en, "rd_en", (MUL*AW)'(bus.rd_en_o), (MUL*AW)'(sb[0].en));
          chk(bus.rd_addr_o == sb[0].addr, "rd_addr", bus.rd_addr_o, sb[0].addr);
        end
      end else begin
        chk(bus.rd_en_o == '0, "idle_en", (MUL*AW)'(bus.rd_en_o), 0);
        chk(sb.size() == 0, "idle_pending", (MUL*AW)'(sb.size()), 0);
      end
    end
  end

  task automatic run_seq(input bit m, input logic [AW-1:0] b, input logic [7:0] n,
                         input int stall_pct, input int stall_at, input int stall_len,
                         input bit mid_start, input int abort_at);
    int k;
    @(negedge clk);
    bus.start_i     = 1'b1;
    bus.mode_i      = m;
    bus.base_addr_i = b;
    bus.num_rows_i  = n;
    bus.stall_i     = 1'b0;
    push_exp(m, b, n);
    k = 0;
    while (sb.size() > 0 && k < 2000) begin
      @(negedge clk);
      k++;
      bus.start_i     = mid_start ? ($urandom_range(0, 3) == 0) : 1'b0;
      bus.mode_i      = 1'($urandom);
      bus.base_addr_i = AW'($urandom);
      bus.num_rows_i  = 8'($urandom);
      if (stall_at >= 0) bus.stall_i = (k > stall_at) && (k <= stall_at + stall_len);
      else               bus.stall_i = ($urandom_range(0, 99) < stall_pct);
      if (abort_at >= 0 && k == abort_at + 1) begin
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        bus.start_i = 1'b0;
        rst = 1'b0;
      end
    end
    if (k >= 2000) begin
      chk(1'b0, "drain_timeout", (MUL*AW)'(sb.size()), 0);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
    end
    bus.start_i = 1'b0;
    bus.stall_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  initial begin : driver
    bus.start_i     = 1'b0;
    bus.mode_i      = 1'b0;
    bus.base_addr_i = '0;
    bus.num_rows_i  = '0;
    bus.stall_i     = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_seq(1'b0, 7'd5,   8'd4,   0, -1, 0, 1'b0, -1);
    run_seq(1'b1, 7'd0,   8'd2,   0, -1, 0, 1'b0, -1);
    run_seq(1'b0, 7'd126, 8'd4,   0, -1, 0, 1'b0, -1);
    run_seq(1'b1, 7'd10,  8'd3,   0,  5, 3, 1'b0, -1);
    run_seq(1'b1, 7'd20,  8'd10,  0, -1, 0, 1'b1,  7);
    run_seq(1'b0, 7'd3,   8'd5,   0, -1, 0, 1'b1, -1);
    run_seq(1'b0, 7'd50,  8'd0,   0, -1, 0, 1'b0, -1);
    run_seq(1'b1, 7'd50,  8'd0,   0, -1, 0, 1'b0, -1);
    run_seq(1'b0, 7'd100, 8'd200, 0, -1, 0, 1'b0, -1);
    run_seq(1'b1, 7'd100, 8'd200, 20, -1, 0, 1'b1, -1);
    run_seq(1'b1, 7'd127, 8'd128, 0, -1, 0, 1'b0, -1);

    for (int i = 0; i < 24; i++) begin
      logic [7:0] n;
      n = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
      run_seq(1'($urandom), AW'($urandom), n, $urandom_range(0, 40), -1, 0,
              1'($urandom), ($urandom_range(0, 5) == 0) ? $urandom_range(0, 20) : -1);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_rd_addr_gen.md
# acc_rd_addr_gen

Read-address sequencer for the 32-column accumulator memory. On a start command it walks a block of accumulator rows and drives per-column read enables and 7-bit addresses in either `NORMAL` (all columns same row) or `DIAG` (column c lagging c cycles) order. `DIAG` order re-skews results leaving the systolic array. The block sits between the control unit and the accumulator banks, and replaces the compile-time diagonal-address LUT with a run-time counter.

## Interface
Parameters:
- `MUL_SIZE`, 32, number of accumulator columns/banks
- `ADDR_W`, 7, accumulator row address width (128 rows)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `start_i`  in  1  request a new read sequence; sampled only in IDLE
- `mode_i`  in  1  `acc_rd_mode` (`NORMAL`=0, `DIAG`=1); sampled with `start_i`
- `base_addr_i`  in  ADDR_W  first row; sampled with `start_i`
- `num_rows_i`  in  8  rows to read, 0..128; values >128 clamp to 128; sampled with `start_i`
- `stall_i`  in  1  consumer back-pressure; step is consumed only on a cycle with `stall_i`=0
- `busy_o`  out  1  high in RUN
- `done_o`  out  1  one-cycle pulse after the final step is consumed
- `rd_en_o`  out  MUL_SIZE  per-column read enable
- `rd_addr_o`  out  MUL_SIZE*ADDR_W  column c address at bits [c*ADDR_W +: ADDR_W]

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when `start_i`=1. Mode, base, and clamped row count R are latched, and step counter t is set to 0.
- IDLE → DONE directly when `start_i`=1 and R=0. No `rd_en_o` is ever asserted in this case.
- RUN: outputs present step t. If `stall_i`=0, t increments; when t = last step, the FSM goes to DONE. If `stall_i`=1, all state and outputs hold.
- Last step is R-1 in `NORMAL` and R+MUL_SIZE-2 in `DIAG`.
- DONE: `done_o`=1 for exactly one cycle, `rd_en_o`=0, then → IDLE.
- `NORMAL` step t: all columns enabled; every address = (base + t) mod 128.
- `DIAG` step t: column c is enabled iff c ≤ t < c+R. Its address = (base + t − c) mod 128. Disabled columns drive address 0.
- Address arithmetic is ADDR_W-bit modular; base+R crossing 127 wraps to 0.
- `start_i` in RUN or DONE is ignored; it is not queued.
- `rst` takes priority over everything and returns the FSM to IDLE from any state, including mid-sequence. No `done_o` is generated for an aborted sequence.
- Reset values: `busy_o`=0, `done_o`=0, `rd_en_o`=0, `rd_addr_o`=0, t=0, state IDLE.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- `start_i` accepted at edge N → step 0 visible after edge N, `busy_o`=1 in the same cycle.
- With no stalls, `NORMAL` occupies R cycles of RUN, and `DIAG` occupies R+31 cycles. `done_o` follows in the next cycle, and the earliest next `start_i` is accepted the cycle after `done_o`.
- The stall decision for step t uses `stall_i` in the cycle step t is presented. Stall has 0-cycle hold latency: the outputs on the next edge are unchanged.
- Throughput: one step per unstalled cycle.
- R=0: `done_o` high in the cycle after the start edge; `busy_o` never asserts.

## Test plan
- Reset then `NORMAL`, base=5, R=4, no stall → 4 RUN cycles, all 32 enables high, addresses 5,6,7,8, then `done_o` pulse, `busy_o` low.
- `DIAG`, base=0, R=2 → 33 RUN cycles. At t=0 only col0 is enabled (addr 0). At t=1, col0=1 and col1=0. At t=32, only col31 is enabled (addr 1). `done_o` follows.
- `NORMAL`, base=126, R=4 → addresses 126,127,0,1 (wrap), then done.
- `DIAG`, base=10, R=3, `stall_i`=1 for 3 cycles at t=5 → outputs frozen for 3 cycles at col5 addr 10, col4 addr 11, col3 addr 12. Total RUN length is 34+3 cycles.
- Mid-RUN `start_i` pulses are ignored. `rst` asserted at t=7 of a `DIAG` run → next cycle all enables 0, `busy_o` 0, no `done_o`. A new start is then accepted normally.
- R=0 start → `done_o` one cycle after start, no enables. `num_rows_i`=200 behaves exactly as 128.
